rv_mem_arb: RTL and testbench

- Arbiter and sequencer for the single shared memory of the multicycle RISC-V model.
- Shares the memory between two requesters: the core (driven by the control FSM and datapath) and a debug/loader port used for program loading and inspection.
- Serialises accesses, holds the memory interface for a fixed latency, and returns a one-cycle completion pulse plus read data to the granted requester.

---
 rtl/rv_mem_arb.sv | 142 ++++++++++++++
 tb/tb_rv_mem_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shared-memory arbiter/sequencer for the multicycle core.
// Arbitrates core (c_*) vs debug/loader (d_*) ports, drives mem_* for
//   MEM_LAT cycles, then pulses c_done/d_done with c_rdata/d_rdata held.
// Status: busy (not IDLE), owner (current/last grant, 1=debug).
// Option: define RV_MEM_ARB_DBG_PRIO_EN for fixed debug priority.
module rv_mem_arb #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  generate
    if (MEM_LAT < 1) begin : g_lat_chk
      $error("rv_mem_arb: MEM_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   c_rdata_q, c_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            win;

  // win=1 grants debug
`ifdef RV_MEM_ARB_DBG_PRIO_EN
  assign win = d_req;
`else
  assign win = d_req & (~c_req | ~last_q);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (c_req | d_req) begin
          owner_d = win;
          we_d    = win ? d_we    : c_we;
          addr_d  = win ? d_addr  : c_addr;
          wdata_d = win ? d_wdata : c_wdata;
          cnt_d   = CW'(MEM_LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         c_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // memory bus is quiet outside ACCESS
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign c_done    = (state_q == DONE) & ~owner_q;
  assign d_done    = (state_q == DONE) &  owner_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: directed plus random checks of rv_mem_arb
// against a transaction-level timing model.
module tb_rv_mem_arb;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata, mem_rdata;
  logic          c_done, d_done, mem_en, mem_we, busy, owner;
  logic [DW-1:0] c_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  rv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // transaction model: a grant at edge E opens a window of
  // LAT access cycles, then one done cycle, then idle
  bit            m_act  = 0;
  int            m_n    = 0;
  bit            m_own  = 0;
  bit            m_last = 1;
  bit            m_we   = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd   = '0;
  logic [DW-1:0] m_crd  = '0;
  logic [DW-1:0] m_drd  = '0;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit pick(input bit cr, input bit dr,
                              input bit last);
`ifdef RV_MEM_ARB_DBG_PRIO_EN
    return dr;
`else
    if (cr && dr) return ~last;
    return dr;
`endif
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_act = 0; m_last = 1; m_own = 0; m_we = 0;
      m_addr = '0; m_wd = '0; m_crd = '0; m_drd = '0;
    end else if (m_act) begin
      m_n++;
      if (m_n == LAT && !m_we) begin
        if (m_own) m_drd = mem_rdata;
        else       m_crd = mem_rdata;
      end
      if (m_n == LAT + 1) begin
        m_act  = 0;
        m_last = m_own;
      end
    end else if (c_req || d_req) begin
      m_own  = pick(c_req, d_req, m_last);
      m_we   = m_own ? d_we    : c_we;
      m_addr = m_own ? d_addr  : c_addr;
      m_wd   = m_own ? d_wdata : c_wdata;
      m_n    = 0;
      m_act  = 1;
    end
  endtask

  task automatic compare();
    bit en, dn;
    en = m_act && (m_n < LAT);
    dn = m_act && (m_n == LAT);
    chk("busy",    DW'(busy),   DW'(m_act));
    chk("mem_en",  DW'(mem_en), DW'(en));
    chk("mem_we",  DW'(mem_we), DW'(en && m_we));
    chk("c_done",  DW'(c_done), DW'(dn && !m_own));
    chk("d_done",  DW'(d_done), DW'(dn && m_own));
    chk("owner",   DW'(owner),  DW'(m_own));
    chk("c_rdata", c_rdata, m_crd);
    chk("d_rdata", d_rdata, m_drd);
    if (en) begin
      chk("mem_addr", DW'(mem_addr), DW'(m_addr));
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  int order[$];
  int ncd;

  initial begin
    rst_n = 0; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    cyc(); cyc();
    chk("rst_busy",  DW'(busy),  0);
    chk("rst_owner", DW'(owner), 0);
    chk("rst_crd",   c_rdata,    0);
    chk("rst_drd",   d_rdata,    0);

    // core read, address change during access
    rst_n = 1; c_req = 1; c_addr = 10'h010;
    mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("t1_en",   DW'(mem_en),   1);
    chk("t1_we",   DW'(mem_we),   0);
    chk("t1_addr", DW'(mem_addr), 32'h010);
    c_req = 0; c_addr = 10'h3FF;
    cyc();
    chk("t1_addr2", DW'(mem_addr), 32'h010);
    cyc();
    chk("t1_done",  DW'(c_done), 1);
    chk("t1_ddone", DW'(d_done), 0);
    chk("t1_rdata", c_rdata, 32'hDEADBEEF);
    cyc();
    chk("t1_done0", DW'(c_done), 0);

    // debug write
    d_req = 1; d_we = 1; d_addr = 10'h020; d_wdata = 32'h12345678;
    cyc();
    chk("t2_we",  DW'(mem_we), 1);
    chk("t2_wd",  mem_wdata,   32'h12345678);
    d_req = 0;
    cyc();
    chk("t2_wd2", mem_wdata,   32'h12345678);
    cyc();
    chk("t2_done",  DW'(d_done), 1);
    chk("t2_owner", DW'(owner),  1);
    chk("t2_drd",   d_rdata,     0);
    cyc();

    // both request from reset
    rst_n = 0; d_we = 0; cyc();
    rst_n = 1; c_req = 1; d_req = 1;
    cyc(); cyc(); cyc();
`ifndef RV_MEM_ARB_DBG_PRIO_EN
    chk("t3_cdone", DW'(c_done), 1);
`endif
    c_req = 0;
    cyc();
`ifndef RV_MEM_ARB_DBG_PRIO_EN
    chk("t3_idle", DW'(busy), 0);
`endif
    cyc();
`ifndef RV_MEM_ARB_DBG_PRIO_EN
    chk("t3_acc", DW'(mem_en), 1);
    chk("t3_own", DW'(owner),  1);
`endif
    cyc(); cyc();
`ifndef RV_MEM_ARB_DBG_PRIO_EN
    chk("t3_ddone", DW'(d_done), 1);
`endif
    d_req = 0;
    cyc(); cyc();

    // both held: completion order
    c_req = 1; d_req = 1;
    for (int i = 0; i < 100 && order.size() < 8; i++) begin
      cyc();
      if (c_done) order.push_back(0);
      if (d_done) order.push_back(1);
    end
    c_req = 0; d_req = 0;
    chk("t4_count", DW'(order.size()), 8);
    foreach (order[i]) begin
`ifdef RV_MEM_ARB_DBG_PRIO_EN
      chk("t4_order", DW'(order[i]), 1);
`else
      chk("t4_order", DW'(order[i]), DW'(i % 2));
`endif
    end
    cyc(); cyc();

    // reset in first access cycle of a core write
    c_req = 1; c_we = 1; c_addr = 10'h055; c_wdata = $urandom;
    cyc();
    chk("t5_acc", DW'(mem_en), 1);
    rst_n = 0; c_req = 0;
    cyc();
    chk("t5_busy", DW'(busy),   0);
    chk("t5_en",   DW'(mem_en), 0);
    chk("t5_we",   DW'(mem_we), 0);
    rst_n = 1;
    ncd = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (c_done) ncd++;
    end
    chk("t5_nodone", DW'(ncd), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      c_req     = ($urandom_range(0, 3) != 0);
      d_req     = ($urandom_range(0, 2) == 0);
      c_we      = $urandom_range(0, 1);
      d_we      = $urandom_range(0, 1);
      c_addr    = AW'($urandom);
      d_addr    = AW'($urandom);
      c_wdata   = $urandom;
      d_wdata   = $urandom;
      mem_rdata = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
